// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file writer: register index width,
// the zero word, and the write-port arbitration source encoding.
package wb_arbiter_pkg;

    localparam int          REG_IDX_W = 5;
    localparam logic [31:0] ZERO      = 32'h0;

    typedef enum logic [1:0] {
        SRC_IDLE   = 2'd0,
        SRC_ALU    = 2'd1,
        SRC_QUEUE  = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of ALU result, load result and register-file write port signals.
// The arbiter is the slave side; the core pipeline (or a bench) is the master.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = REG_IDX_W,
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              busy;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output ld_ready, write_enable, write_addr, write_data, busy
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  ld_ready, write_enable, write_addr, write_data, busy
    );
endinterface

// File: rtl/wb_arbiter_queue.sv
// Circular load-result FIFO with a live bit per entry; a parallel compare
// against kill_rd_i clears the live bit of every entry targeting that register.
module wb_queue
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_IDX_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              push_live_i,
    input  logic [ADDR_W-1:0] push_rd_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              kill_i,
    input  logic [ADDR_W-1:0] kill_rd_i,
    output logic              empty_o,
    output logic              full_o,
    output logic              head_live_o,
    output logic [ADDR_W-1:0] head_rd_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              busy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [DEPTH-1:0]  live_q;
    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Storage, pointers and live bits; push after pop so a fresh entry wins its slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            live_q   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= {ADDR_W{1'b0}};
                data_q[i] <= DATA_W'(ZERO);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_i && (rd_q[i] == kill_rd_i)) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (pop_i) begin
                live_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i) begin
                live_q[wr_ptr_q] <= push_live_i;
                rd_q[wr_ptr_q]   <= push_rd_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign empty_o     = (count_q == {CNT_W{1'b0}});
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign head_live_o = live_q[rd_ptr_q];
    assign head_rd_o   = rd_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign busy_o      = |live_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: ALU results first, then queued loads,
// then a same-cycle load bypass when the queue is empty. Outputs are registered.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_IDX_W,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    wb_src_e           src_s;
    logic              ld_accept_s;
    logic              kill_en_s;
    logic              push_s;
    logic              push_live_s;
    logic              pop_s;
    logic              q_empty_s;
    logic              q_full_s;
    logic              q_busy_s;
    logic              head_live_s;
    logic [ADDR_W-1:0] head_rd_s;
    logic [DATA_W-1:0] head_data_s;

    logic              write_enable_q, write_enable_d;
    logic [ADDR_W-1:0] write_addr_q,   write_addr_d;
    logic [DATA_W-1:0] write_data_q,   write_data_d;

    assign bus.ld_ready = rst & ~q_full_s;
    assign bus.busy     = rst & q_busy_s;
    assign ld_accept_s  = bus.ld_valid & bus.ld_ready;
    assign kill_en_s    = bus.alu_valid & (bus.alu_rd != {ADDR_W{1'b0}});
    // A load accepted alongside the ALU is older, so a matching ALU rd supersedes it.
    assign push_live_s  = ~(kill_en_s & (bus.ld_rd == bus.alu_rd));
    assign pop_s        = (src_s == SRC_QUEUE);
    assign push_s       = ld_accept_s & (src_s != SRC_BYPASS);

    // Priority select of this cycle's write-port owner.
    always_comb begin
        src_s = SRC_IDLE;
        if (bus.alu_valid) begin
            src_s = SRC_ALU;
        end else if (!q_empty_s) begin
            src_s = SRC_QUEUE;
        end else if (ld_accept_s) begin
            src_s = SRC_BYPASS;
        end else begin
            src_s = SRC_IDLE;
        end
    end

    // Next value of the write port; address/data hold when nothing is written.
    always_comb begin
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        case (src_s)
            SRC_ALU: begin
                write_enable_d = (bus.alu_rd != {ADDR_W{1'b0}});
                write_addr_d   = bus.alu_rd;
                write_data_d   = bus.alu_data;
            end
            SRC_QUEUE: begin
                if (head_live_s) begin
                    write_enable_d = (head_rd_s != {ADDR_W{1'b0}});
                    write_addr_d   = head_rd_s;
                    write_data_d   = head_data_s;
                end else begin
                    write_enable_d = 1'b0;
                end
            end
            SRC_BYPASS: begin
                write_enable_d = (bus.ld_rd != {ADDR_W{1'b0}});
                write_addr_d   = bus.ld_rd;
                write_data_d   = bus.ld_data;
            end
            default: begin
                write_enable_d = 1'b0;
            end
        endcase
    end

    // Write port output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_enable_q <= 1'b0;
            write_addr_q   <= {ADDR_W{1'b0}};
            write_data_q   <= DATA_W'(ZERO);
        end else begin
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
        end
    end

    assign bus.write_enable = write_enable_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.write_data   = write_data_q;

    wb_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_live_i (push_live_s),
        .push_rd_i   (bus.ld_rd),
        .push_data_i (bus.ld_data),
        .pop_i       (pop_s),
        .kill_i      (kill_en_s),
        .kill_rd_i   (bus.alu_rd),
        .empty_o     (q_empty_s),
        .full_o      (q_full_s),
        .head_live_o (head_live_s),
        .head_rd_o   (head_rd_s),
        .head_data_o (head_data_s),
        .busy_o      (q_busy_s)
    );

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writer side of the register file.
- Merges results from the ALU path (no backpressure) and the load path (memory, variable latency, backpressured) onto the single register-file write port (write_enable / write_addr / write_data).
- Buffers load results in a small queue while the ALU owns the port.
- Kills queued load results that a younger ALU write to the same register has superseded.

Parameters:
DEPTH, 4, load-result queue entries (power of two, >= 2)
ADDR_W, 5, register index width
DATA_W, 32, register data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
alu_valid  in  1  ALU result present this cycle
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load result accepted when ld_valid & ld_ready
ld_rd  in  ADDR_W  load destination register
ld_data  in  DATA_W  load data
write_enable  out  1  register-file write strobe
write_addr  out  ADDR_W  register-file write index
write_data  out  DATA_W  register-file write data
busy  out  1  queue holds at least one live entry

Behaviour:
- Reset (rst==0 at posedge clk):
  - write_enable=0, write_addr=0, write_data=0.
  - Queue emptied; all entry valid bits cleared.
  - ld_ready=0 and busy=0 while rst==0.
  - A result mid-queue at reset is lost. This is by design; the core is also reset.
- All write-port outputs are registered. Each result reaches the port exactly 1 cycle after the cycle it wins arbitration.
- ld_ready = rst & (queue count < DEPTH). It is combinational from registered state only and does not depend on ld_valid.
- Arbitration each cycle, in priority order:
  1. alu_valid=1: the ALU result wins. Next cycle write_enable=(alu_rd!=0), write_addr=alu_rd, write_data=alu_data.
  2. Else, queue non-empty: pop the head. If the head is live and rd!=0, write it. If the head is killed, pop it and set write_enable=0 (one idle cycle per killed entry).
  3. Else, ld_valid & ld_ready with an empty queue: bypass. Write the load next cycle, without enqueuing.
  4. Else: write_enable=0. write_addr and write_data hold their previous values.
- Enqueue:
  - An accepted load that is not bypassed is enqueued at the tail.
  - Enqueue and pop in the same cycle are both honoured; count is unchanged.
  - When full with a pop this cycle, ld_ready is still 0. No enqueue-on-pop.
- Kill rule (ordering): on every cycle with alu_valid=1 and alu_rd!=0:
  - Every live queue entry with rd==alu_rd is marked killed.
  - An accepted load this same cycle with ld_rd==alu_rd is also killed. Same-cycle load is defined as older than the ALU result, so it is enqueued as killed.
- ld_rd==0: accepted and consumed, never written (write_enable=0 when it reaches the head or bypasses).
- busy = at least one entry with the live bit set (killed entries excluded).
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- No write-to-read forwarding here; the register file handles it.

Decomposition:
- Shared defines header gets `Zero (32'h0) and the register-index width, used by both the register file and this block.
- One natural sub-module, wb_queue: circular FIFO with per-entry live bits and a parallel kill-by-rd compare input.
- Arbitration and output registers stay in wb_arbiter.

Test Plan:
- Reset: hold rst=0 3 cycles with alu_valid=1 -> write_enable=0, write_addr=0, write_data=0, ld_ready=0, busy=0 throughout. Release -> ld_ready=1 the same cycle.
- ALU latency: alu_valid=1, rd=5, data=32'hDEADBEEF at cycle N -> cycle N+1 shows write_enable=1, addr=5, data=DEADBEEF. alu_rd=0 -> write_enable=0.
- Bypass vs queue:
  - Load rd=7, data=0x11 with idle ALU and empty queue -> written next cycle, busy stays 0.
  - Same load while alu_valid=1 -> queued, busy=1, written in the first ALU-idle cycle.
- Full/backpressure: ALU busy every cycle, offer 5 loads with DEPTH=4 -> ld_ready drops after the 4th. When the ALU idles, 4 writes occur in order, then the 5th load is accepted.
- Kill: queue load rd=3 data=0xAA, then ALU rd=3 data=0xBB -> exactly one write to x3 (0xBB), followed by one idle pop cycle. Same-cycle load rd=3 with ALU rd=3 -> only the ALU value is written.
- Reset mid-operation: 3 queued loads, assert rst=0 one cycle -> queue empty, busy=0, no further writes after release.
